// File: rtl/nabp_angle_sequencer_if.sv
// Handshake bundle between the angle sequencer, the swap control
// and the filtered-RAM loader. master = sequencer side.
interface nabp_angle_sequencer_if #(
    parameter int ANGLE_W = 9
);
    logic               sc_next_angle;
    logic               sc_next_angle_ack;
    logic [ANGLE_W-1:0] sc_angle;
    logic               sc_bank;
    logic               fr_load_req;
    logic [ANGLE_W-1:0] fr_load_angle;
    logic               fr_load_bank;
    logic               fr_load_done;

    modport master (
        input  sc_next_angle,
        input  fr_load_done,
        output sc_next_angle_ack,
        output sc_angle,
        output sc_bank,
        output fr_load_req,
        output fr_load_angle,
        output fr_load_bank
    );

    modport slave (
        output sc_next_angle,
        output fr_load_done,
        input  sc_next_angle_ack,
        input  sc_angle,
        input  sc_bank,
        input  fr_load_req,
        input  fr_load_angle,
        input  fr_load_bank
    );
endinterface

// File: rtl/nabp_angle_sequencer.sv
// Angle sequencer: loads each filtered line, then hands its angle to the
// swap control. Define NABP_ANGLE_SEQ_PREFETCH_EN for double-buffering.
module nabp_angle_sequencer #(
    parameter int ANGLE_W      = 9,
    parameter int NO_OF_ANGLES = 180,
    parameter int ANGLE_INIT   = 0,
    parameter int ANGLE_STEP   = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    output logic busy,
    output logic done,
    nabp_angle_sequencer_if.master bus
);
    localparam int IDX_W = (NO_OF_ANGLES > 1) ? $clog2(NO_OF_ANGLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NO_OF_ANGLES - 1);
    localparam logic [ANGLE_W-1:0] A_INIT = ANGLE_W'(ANGLE_INIT);
    localparam logic [ANGLE_W-1:0] A_STEP = ANGLE_W'(ANGLE_STEP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READY,
        S_WAIT,
        S_FINISH
    } state_t;

`ifdef NABP_ANGLE_SEQ_PREFETCH_EN
    localparam state_t AFTER_ACK = S_LOAD;
    localparam logic   BANK_FLIP = 1'b1;
`else
    localparam state_t AFTER_ACK = S_WAIT;
    localparam logic   BANK_FLIP = 1'b0;
`endif

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [ANGLE_W-1:0] angle_q;
    logic               bank_q;
    logic               ack_q;
    logic [ANGLE_W-1:0] sc_angle_q;
    logic               sc_bank_q;
    logic               busy_q;
    logic               done_q;
    logic               go;
    logic               issue;
    logic               last;
    logic               finish;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next state and the one-cycle control strobes.
    always_comb begin
        state_d = state_q;
        go      = 1'b0;
        issue   = 1'b0;
        finish  = 1'b0;
        last    = (idx_q == IDX_LAST);
        unique case (state_q)
            S_IDLE: if (start) begin
                go      = 1'b1;
                state_d = S_LOAD;
            end
            S_LOAD: if (bus.fr_load_done) state_d = S_READY;
            S_READY: if (bus.sc_next_angle) begin
                issue   = 1'b1;
                state_d = last ? S_FINISH : AFTER_ACK;
            end
            S_WAIT: if (bus.sc_next_angle) state_d = S_LOAD;
            S_FINISH: if (bus.sc_next_angle) begin
                finish  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Angle accumulator, index, bank and registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q      <= '0;
            angle_q    <= '0;
            bank_q     <= 1'b0;
            ack_q      <= 1'b0;
            sc_angle_q <= '0;
            sc_bank_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ack_q  <= issue;
            done_q <= finish;
            if (go) begin
                idx_q   <= '0;
                angle_q <= A_INIT;
                bank_q  <= 1'b0;
                busy_q  <= 1'b1;
            end
            if (issue) begin
                sc_angle_q <= angle_q;
                sc_bank_q  <= bank_q;
                if (!last) begin
                    idx_q   <= idx_q + IDX_W'(1);
                    angle_q <= angle_q + A_STEP;
                    bank_q  <= bank_q ^ BANK_FLIP;
                end
            end
            if (finish) busy_q <= 1'b0;
        end
    end

    assign busy                  = busy_q;
    assign done                  = done_q;
    assign bus.sc_next_angle_ack = ack_q;
    assign bus.sc_angle          = sc_angle_q;
    assign bus.sc_bank           = sc_bank_q;
    assign bus.fr_load_req       = (state_q == S_LOAD);
    assign bus.fr_load_angle     = angle_q;
    assign bus.fr_load_bank      = bank_q;
endmodule

// File: tb/tb_nabp_angle_sequencer.sv
// Randomized bench for nabp_angle_sequencer: a 4-angle and a 1-angle
// instance checked against the expected angle/bank schedule.
module tb_nabp_angle_sequencer;
    localparam int AW   = 9;
    localparam int INIT = 0;
    localparam int STEP = 45;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic start   = 1'b0;
    logic sc      = 1'b0;
    logic frd     = 1'b0;
    int   sel     = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic start_a, start_b, busy_a, busy_b, done_a, done_b;

    nabp_angle_sequencer_if #(.ANGLE_W(AW)) ia ();
    nabp_angle_sequencer_if #(.ANGLE_W(AW)) ib ();

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign ia.sc_next_angle = sc;
    assign ia.fr_load_done  = frd;
    assign ib.sc_next_angle = sc;
    assign ib.fr_load_done  = frd;

    nabp_angle_sequencer #(
        .ANGLE_W(AW), .NO_OF_ANGLES(4), .ANGLE_INIT(INIT), .ANGLE_STEP(STEP)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a),
        .busy(busy_a), .done(done_a), .bus(ia.master)
    );

    nabp_angle_sequencer #(
        .ANGLE_W(AW), .NO_OF_ANGLES(1), .ANGLE_INIT(INIT), .ANGLE_STEP(STEP)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b),
        .busy(busy_b), .done(done_b), .bus(ib.master)
    );

    always #5 clk = ~clk;

    logic          o_busy, o_done, o_ack, o_bank, o_req, o_lbank;
    logic [AW-1:0] o_angle, o_langle;

    always_comb begin
        if (sel == 0) begin
            o_busy = busy_a; o_done = done_a;
            o_ack = ia.sc_next_angle_ack; o_angle = ia.sc_angle;
            o_bank = ia.sc_bank; o_req = ia.fr_load_req;
            o_langle = ia.fr_load_angle; o_lbank = ia.fr_load_bank;
        end else begin
            o_busy = busy_b; o_done = done_b;
            o_ack = ib.sc_next_angle_ack; o_angle = ib.sc_angle;
            o_bank = ib.sc_bank; o_req = ib.fr_load_req;
            o_langle = ib.fr_load_angle; o_lbank = ib.fr_load_bank;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] exp_angle(input int k);
        return AW'(INIT + k * STEP);
    endfunction

    function automatic logic exp_bank(input int k);
`ifdef NABP_ANGLE_SEQ_PREFETCH_EN
        return logic'(k % 2);
`else
        return 1'b0 & logic'(k);
`endif
    endfunction

    task automatic check_all_zero(input string tag);
        check(tag, {o_busy, o_done, o_ack, o_bank, o_req, o_lbank,
                    o_angle, o_langle}, 0);
    endtask

    // One run from start to done (or abort by reset at load abort_load).
    // Called at a negedge; returns at a negedge unless aborted.
    task automatic run(input int n, input int lat_min, input int lat_max,
                       input int sc_pct, input int abort_load);
        int      loads = 0, acks = 0, lat = 0, cyc = 0, fall_cyc = -100;
        bit      prev_req = 0, prev_sc = 0, fin = 0;
        logic    last_ack_bank = 0;
        logic [AW-1:0] held = '0;
        start = 1'b1;
        prev_sc = sc;
        @(negedge clk);
        start = 1'b0;
        check("busy_start", o_busy, 1);
        while (!fin) begin
            cyc++;
            if (cyc > 3000) begin
                check("run_timeout", 0, 1);
                break;
            end
            if (o_ack) begin
                check("ack_req", prev_sc, 1);
                check("ack_after_load", prev_req, 0);
                check("ack_angle", o_angle, exp_angle(acks));
                check("ack_bank", o_bank, exp_bank(acks));
                if (sc_pct == 100) check("ack_lat", cyc - fall_cyc, 1);
                last_ack_bank = o_bank;
                acks++;
            end
            if (o_req && !prev_req) begin
                check("load_angle", o_langle, exp_angle(loads));
                check("load_bank", o_lbank, exp_bank(loads));
`ifdef NABP_ANGLE_SEQ_PREFETCH_EN
                if (acks > 0) check("load_other_bank", o_lbank != last_ack_bank, 1);
`else
                if (loads > 0) check("load_after_req", prev_sc, 1);
`endif
                held = o_langle;
                lat = $urandom_range(lat_max, lat_min);
                loads++;
                if (loads == abort_load) begin
                    reset_n = 1'b0;
                    #1;
                    check_all_zero("abort_outs");
                    start = 1'b0;
                    frd = 1'b0;
                    return;
                end
            end else if (o_req) begin
                check("load_stable", {o_lbank, o_langle},
                      {exp_bank(loads - 1), held});
            end
            if (!o_req && prev_req) fall_cyc = cyc;
            if (o_done) begin
                fin = 1;
                check("done_busy", o_busy, 0);
                check("run_acks", acks, n);
                check("run_loads", loads, n);
            end
            prev_req = o_req;
            frd = 1'b0;
            if (o_req && lat > 0) begin
                lat--;
                if (lat == 0) frd = 1'b1;
            end else if (!o_req && $urandom_range(9, 0) == 0) begin
                frd = 1'b1;
            end
            sc = ($urandom_range(99, 0) < sc_pct);
            start = o_busy && !fin && ($urandom_range(7, 0) == 0);
            prev_sc = sc;
            @(negedge clk);
        end
        start = 1'b0;
        frd = 1'b0;
        check("done_pulse", o_done, 0);
        check("idle_busy", o_busy, 0);
        @(negedge clk);
        check("idle_req", o_req, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_all_zero("reset_outs");
        reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset_outs");

        sel = 0;
        run(4, 3, 3, 100, 0);
        run(4, 20, 20, 100, 0);
        for (int r = 0; r < 8; r++) run(4, 1, 6, 55, 0);
        run(4, 2, 5, 80, 2);
        @(negedge clk);
        check_all_zero("abort_held");
        reset_n = 1'b1;
        @(negedge clk);
        run(4, 1, 5, 60, 0);

        sel = 1;
        @(negedge clk);
        run(1, 3, 3, 100, 0);
        run(1, 1, 5, 40, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
